// File: rtl/ysyx_cdb_arb_pkg.sv
// Shared constants for the CDB arbiter slice.
// Requester indices and the ROB tag width derivation.
package ysyx_cdb_arb_pkg;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_SYS = 2;

  localparam int YSYX_ROB_SIZE = 8;

  // Tag carries one extra bit beyond the ROB index (wrap bit).
  function automatic int calc_dw(input int rob_size);
    return $clog2(rob_size) + 1;
  endfunction

  localparam int YSYX_DW = calc_dw(YSYX_ROB_SIZE);

endpackage

// File: rtl/ysyx_rr_pick.sv
// Rotate-priority one-hot picker.
// Scans from i_ptr upward, wrapping at N.
module ysyx_rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/ysyx_cdb_arb.sv
// Round-robin arbiter driving the common data bus.
// One grant per cycle into a single output register.
module ysyx_cdb_arb
  import ysyx_cdb_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int XLEN     = 32,
  parameter int ROB_SIZE = YSYX_ROB_SIZE,
  parameter int MW       = 48,
  parameter int DW       = calc_dw(ROB_SIZE),
  parameter int PW       = $clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*DW-1:0]   req_dest,
  input  logic [N_REQ*XLEN-1:0] req_result,
  input  logic [N_REQ*MW-1:0]   req_meta,
  output logic                  cdb_valid,
  input  logic                  cdb_ready,
  output logic [DW-1:0]         cdb_dest,
  output logic [XLEN-1:0]       cdb_result,
  output logic [MW-1:0]         cdb_meta,
  output logic [PW-1:0]         cdb_src
);

  logic [PW-1:0]    r_ptr;
  logic             r_valid;
  logic [DW-1:0]    r_dest;
  logic [XLEN-1:0]  r_result;
  logic [MW-1:0]    r_meta;
  logic [PW-1:0]    r_src;

  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic             w_can_acc;
  logic             w_en;
  logic             w_take;
  logic [PW-1:0]    w_ptr_nxt;
  logic [DW-1:0]    w_dest;
  logic [XLEN-1:0]  w_result;
  logic [MW-1:0]    w_meta;

  ysyx_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_can_acc = !r_valid | cdb_ready;
  assign w_en      = w_can_acc & !flush;
  assign w_take    = w_en & w_any;
  assign req_ready = w_en ? w_gnt : '0;

  // Explicit wrap so non-power-of-two N_REQ never holds ptr=N_REQ.
  assign w_ptr_nxt = (w_idx == PW'(N_REQ-1))
                   ? '0 : w_idx + 1'b1;

  always_comb begin
    w_dest   = '0;
    w_result = '0;
    w_meta   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_dest   = req_dest[i*DW +: DW];
        w_result = req_result[i*XLEN +: XLEN];
        w_meta   = req_meta[i*MW +: MW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_dest   <= '0;
      r_result <= '0;
      r_meta   <= '0;
      r_src    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_can_acc) begin
      r_valid <= w_any;
      if (w_take) begin
        r_dest   <= w_dest;
        r_result <= w_result;
        r_meta   <= w_meta;
        r_src    <= w_idx;
        r_ptr    <= w_ptr_nxt;
      end
    end
  end

  assign cdb_valid  = r_valid;
  assign cdb_dest   = r_dest;
  assign cdb_result = r_result;
  assign cdb_meta   = r_meta;
  assign cdb_src    = r_src;

endmodule

// File: tb/tb_ysyx_cdb_arb.sv
// Directed bench for the CDB round-robin arbiter.
// Inputs change 1ns after posedge; checks follow 1ns later.
module tb_ysyx_cdb_arb;

  localparam int N  = 3;
  localparam int XL = 32;
  localparam int DW = 4;
  localparam int MW = 48;
  localparam int PW = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_dest;
  logic [N*XL-1:0] req_result;
  logic [N*MW-1:0] req_meta;
  logic            cdb_valid;
  logic            cdb_ready;
  logic [DW-1:0]   cdb_dest;
  logic [XL-1:0]   cdb_result;
  logic [MW-1:0]   cdb_meta;
  logic [PW-1:0]   cdb_src;

  int checks = 0;
  int errors = 0;

  ysyx_cdb_arb dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_result (req_result),
    .req_meta   (req_meta),
    .cdb_valid  (cdb_valid),
    .cdb_ready  (cdb_ready),
    .cdb_dest   (cdb_dest),
    .cdb_result (cdb_result),
    .cdb_meta   (cdb_meta),
    .cdb_src    (cdb_src)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i,
                         input logic [DW-1:0] d,
                         input logic [XL-1:0] r,
                         input logic [MW-1:0] m);
    req_dest[i*DW +: DW]   = d;
    req_result[i*XL +: XL] = r;
    req_meta[i*MW +: MW]   = m;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    req_valid  = '0;
    req_dest   = '0;
    req_result = '0;
    req_meta   = '0;
    cdb_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_ptr", 64'(dut.r_ptr), 64'd0);
    chk("rst_dest", 64'(cdb_dest), 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    tick();

    // single requester
    set_req(1, 4'd5, 32'hDEADBEEF, 48'h1234_5678_9ABC);
    req_valid = 3'b010;
    cdb_ready = 1'b1;
    #1;
    chk("one_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    #1;
    chk("one_valid", 64'(cdb_valid), 64'd1);
    chk("one_dest", 64'(cdb_dest), 64'd5);
    chk("one_res", 64'(cdb_result), 64'hDEADBEEF);
    chk("one_meta", 64'(cdb_meta), 64'h1234_5678_9ABC);
    chk("one_src", 64'(cdb_src), 64'd1);
    chk("one_ptr", 64'(dut.r_ptr), 64'd2);
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'd0);
    chk("idle_ptr", 64'(dut.r_ptr), 64'd2);

    // round-robin from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++)
      set_req(i, DW'(i + 1), XL'(32'h100 + i), MW'(i));
    req_valid = 3'b111;
    cdb_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(1 << (k % 3)));
      tick();
      chk("rr_valid", 64'(cdb_valid), 64'd1);
      chk("rr_src", 64'(cdb_src), 64'(k % 3));
      chk("rr_dest", 64'(cdb_dest), 64'((k % 3) + 1));
    end

    // backpressure
    set_req(0, 4'd3, 32'hAAAA_0000, 48'h0);
    set_req(1, 4'd4, 32'hBBBB_1111, 48'h1);
    req_valid = 3'b001;
    #1;
    chk("bp_load", 64'(req_ready), 64'b001);
    tick();
    chk("bp_dest0", 64'(cdb_dest), 64'd3);
    cdb_ready = 1'b0;
    req_valid = 3'b110;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_hold", 64'(cdb_dest), 64'd3);
      chk("bp_vld", 64'(cdb_valid), 64'd1);
      tick();
    end
    cdb_ready = 1'b1;
    #1;
    chk("bp_rel", 64'(req_ready), 64'b010);
    tick();
    chk("bp_src", 64'(cdb_src), 64'd1);
    chk("bp_dest1", 64'(cdb_dest), 64'd4);

    // flush mid-stream
    set_req(2, 4'd7, 32'hCCCC_2222, 48'h2);
    req_valid = 3'b100;
    #1;
    chk("fl_load", 64'(req_ready), 64'b100);
    tick();
    chk("fl_dest", 64'(cdb_dest), 64'd7);
    chk("fl_ptr0", 64'(dut.r_ptr), 64'd0);
    cdb_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_valid", 64'(cdb_valid), 64'd0);
    chk("fl_ptr", 64'(dut.r_ptr), 64'd0);
    chk("fl_resume", 64'(req_ready), 64'b100);
    tick();
    chk("fl_src", 64'(cdb_src), 64'd2);
    chk("fl_v2", 64'(cdb_valid), 64'd1);

    // reset dominance
    reset = 1'b1;
    flush = 1'b1;
    req_valid = 3'b111;
    cdb_ready = 1'b1;
    tick();
    chk("rd_valid", 64'(cdb_valid), 64'd0);
    chk("rd_dest", 64'(cdb_dest), 64'd0);
    chk("rd_res", 64'(cdb_result), 64'd0);
    chk("rd_meta", 64'(cdb_meta), 64'd0);
    chk("rd_src", 64'(cdb_src), 64'd0);
    chk("rd_ptr", 64'(dut.r_ptr), 64'd0);
    reset = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    #1;
    chk("rd_ready", 64'(req_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
